lcd_pattern_gen: RTL
====================

LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have port PixelClk  input  1  pixel clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_de  input  1  upstream data enable, high during active pixels.
REQ-006 SHALL have port in_hsync  input  1  upstream HSYNC, active-low.
REQ-007 SHALL have port in_vsync  input  1  upstream VSYNC, active-low.
REQ-008 SHALL have port mode_sel  input  2  requested pattern mode.
REQ-009 SHALL have port mode_valid  input  1  mode_sel valid.
REQ-010 SHALL have port mode_ready  output  1  block can accept a mode request.
REQ-011 SHALL have port LCD_DE  output  1  in_de delayed 1 cycle.
REQ-012 SHALL have port LCD_HSYNC  output  1  in_hsync delayed 1 cycle.
REQ-013 SHALL have port LCD_VSYNC  output  1  in_vsync delayed 1 cycle.
REQ-014 SHALL have port LCD_R  output  5  red.
REQ-015 SHALL have port LCD_G  output  6  green.
REQ-016 SHALL have port LCD_B  output  5  blue.
REQ-017 SHALL have port frame_cnt  output  8  completed-frame counter.

Function
REQ-018 SHALL use one registered stage: all LCD_* outputs reflect the inputs sampled at edge N, updated at edge N+1 (latency 1 cycle, DE/sync/RGB aligned).
REQ-019 SHALL keep x counter (10 bit): 0 while in_de low, +1 per in_de-high cycle, saturating at H_ACTIVE-1.
REQ-020 SHALL keep y counter (9 bit): +1 on in_de falling edge (registered in_de 1, current 0), saturating at V_ACTIVE-1; cleared to 0 on in_vsync falling edge.
REQ-021 SHALL, when in_vsync falling edge and in_de falling edge coincide, clear y (clear wins).
REQ-022 SHALL increment frame_cnt on each in_vsync falling edge, wrapping 255->0.
REQ-023 SHALL accept a mode request when mode_valid && mode_ready: store mode_sel as pending, drop mode_ready next cycle.
REQ-024 SHALL apply pending mode to the active mode on the next in_vsync falling edge, then raise mode_ready next cycle; active mode never changes mid-frame.
REQ-025 SHALL, if acceptance and an in_vsync falling edge occur on the same cycle, apply the new mode at the following frame, not the current edge.
REQ-026 SHALL, in mode 0, output 8 vertical bars each H_ACTIVE/8 wide, left to right: white, yellow, cyan, green, magenta, red, blue, black (full-scale component values 31/63/31).
REQ-027 SHALL, in mode 1, output 32x32 checkerboard: white when x[5]^y[5]=1, else black.
REQ-028 SHALL, in mode 2, output gradient: R=x[9:5] (truncated to 5 bits), G=y[8:3], B=frame_cnt[4:0].
REQ-029 SHALL, in mode 3, output white grid where x[4:0]==0, y[4:0]==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; black elsewhere.
REQ-030 SHALL drive LCD_R/G/B to 0 whenever the registered LCD_DE is 0.

Reset
REQ-031 SHALL, while nRST low, force LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1, RGB=0, x=0, y=0, frame_cnt=0, active and pending mode=0, mode_ready=1.
REQ-032 SHALL, on reset release mid-frame, resume counting from x=0,y=0 with mode 0; y realigns at the next in_vsync falling edge.

Verification
REQ-033 SHALL verify: 800x480 timing, mode 0 -> LCD_DE one cycle after in_de; pixel x=0 white (31,63,31), x=100 yellow (31,63,0), x=799 black.
REQ-034 SHALL verify: mode 1 request accepted at line 10 -> mode_ready=0, pattern stays mode 0 until next in_vsync fall; then x=32,y=0 white, x=32,y=32 black.
REQ-035 SHALL verify: mode_valid with in_vsync falling edge same cycle (mode 2) -> frame after next shows gradient; mode_ready rises one cycle after that application edge.
REQ-036 SHALL verify: 256 frames -> frame_cnt wraps 255->0; mode 2 B component at frame 33 equals 1.
REQ-037 SHALL verify: mode 3 -> x=0,x=32,x=799 and y=479 white; x=5,y=5 black; blanking RGB=0.
REQ-038 SHALL verify: nRST asserted mid-line -> outputs immediately at reset values; after release, counters restart at 0 and mode is 0.

Source files
------------

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator: retimes DE/HSYNC/VSYNC by one PixelClk and overlays one of four patterns.
// Latency 1 cycle; mode requests use valid/ready, held pending until the next VSYNC falling edge.
module lcd_pattern_gen #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480
) (
  input  logic       PixelClk,
  input  logic       nRST,
  input  logic       in_de,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic [1:0] mode_sel,
  input  logic       mode_valid,
  output logic       mode_ready,
  output logic       LCD_DE,
  output logic       LCD_HSYNC,
  output logic       LCD_VSYNC,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B,
  output logic [7:0] frame_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;
  localparam int         BAR_W   = H_ACTIVE / 8;
  localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_MAX   = 9'(V_ACTIVE - 1);

  logic       de_q, hs_q, vs_q;
  logic [4:0] r_q, r_d, b_q, b_d;
  logic [5:0] g_q, g_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [7:0] frame_q, frame_d;
  logic [1:0] mode_q, mode_d, pend_q, pend_d;
  logic [0:0] st_q, st_d;

  logic       vs_fall, de_fall;
  logic [2:0] bar;
  logic       on;
  logic [4:0] pr, pb;
  logic [5:0] pg;

  // Edges are taken against the retimed copies, so they share the output register stage.
  assign vs_fall = vs_q & ~in_vsync;
  assign de_fall = de_q & ~in_de;

  always_comb begin
    x_d = '0;
    if (in_de) x_d = (x_q == X_MAX) ? x_q : x_q + 10'd1;

    y_d = y_q;
    if (vs_fall)                    y_d = '0;
    else if (de_fall && y_q != Y_MAX) y_d = y_q + 9'd1;

    frame_d = frame_q + {7'd0, vs_fall};
  end

  // A request accepted on a VSYNC edge cycle is only applied at the following edge.
  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    mode_d = mode_q;
    case (st_q)
      ST_IDLE: begin
        if (mode_valid) begin
          pend_d = mode_sel;
          st_d   = ST_PEND;
        end
      end
      default: begin
        if (vs_fall) begin
          mode_d = pend_q;
          st_d   = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    bar = '0;
    on  = 1'b0;
    pr  = '0;
    pg  = '0;
    pb  = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x_q) >= BAR_W * k) bar = 3'(k);
    end
    case (mode_q)
      2'd0: begin
        // Bar order white..black maps to the inverted bits of the bar index.
        pr = {5{~bar[1]}};
        pg = {6{~bar[2]}};
        pb = {5{~bar[0]}};
      end
      2'd1: on = x_q[5] ^ y_q[5];
      2'd2: begin
        pr = x_q[9:5];
        pg = y_q[8:3];
        pb = frame_q[4:0];
      end
      default: on = (x_q[4:0] == 5'd0) || (y_q[4:0] == 5'd0) || (x_q == X_MAX) || (y_q == Y_MAX);
    endcase
    if (on) begin
      pr = '1;
      pg = '1;
      pb = '1;
    end
    r_d = in_de ? pr : '0;
    g_d = in_de ? pg : '0;
    b_d = in_de ? pb : '0;
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      st_q    <= ST_IDLE;
    end else begin
      de_q    <= in_de;
      hs_q    <= in_hsync;
      vs_q    <= in_vsync;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      st_q    <= st_d;
    end
  end

  assign mode_ready = (st_q == ST_IDLE);
  assign LCD_DE     = de_q;
  assign LCD_HSYNC  = hs_q;
  assign LCD_VSYNC  = vs_q;
  assign LCD_R      = r_q;
  assign LCD_G      = g_q;
  assign LCD_B      = b_q;
  assign frame_cnt  = frame_q;

endmodule
